// File: rtl/regfile_ba_scoreboard.sv
// General-purpose register file: one write port, two combinational read ports, a configurable
// R0 zero rule (BAout qualifier or hardwired) and a per-register busy scoreboard.
module regfile_ba_scoreboard #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_REGS  = 16,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0,
    parameter int               ZERO_MODE = 1,
    parameter bit               BYPASS    = 1'b1,
    localparam int              AW        = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic             rd_ba_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_busy_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic             rd_ba_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_busy_b,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    output logic             any_busy
);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_hit;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return int'(addr) < NUM_REGS;
    endfunction

    // R0 writes are dropped entirely when R0 is hardwired to zero.
    assign wr_hit = wr_en && in_range(wr_addr) && !(ZERO_MODE == 2 && wr_addr == '0);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && wr_addr == AW'(i)) begin
                busy_d[i] = 1'b0;
            end
            // Set is applied after clear: a new issue wins over the old writeback.
            if (busy_set && busy_addr == AW'(i) && !(ZERO_MODE == 2 && i == 0)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // NOTE: the storage array is reset on purpose -- every register must read INIT_VAL after clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (ZERO_MODE == 2 && i == 0) ? '0 : INIT_VAL;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit && wr_addr == AW'(i)) begin
                    regs_q[i] <= wr_data;
                end
            end
            busy_q <= busy_d;
        end
    end

    assign any_busy = |busy_q;

    // Both read ports share one implementation; index 0 is port A, index 1 is port B.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [AW-1:0]    addr;
        logic             ba;
        logic [WIDTH-1:0] data;
        logic             busy;

        assign addr = (p == 0) ? rd_addr_a : rd_addr_b;
        assign ba   = (p == 0) ? rd_ba_a   : rd_ba_b;

        always_comb begin
            data = '0;
            busy = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == AW'(i)) begin
                    data = regs_q[i];
                    busy = busy_q[i];
                end
            end
            // Forward only a write that will actually commit at this edge.
            if (BYPASS && !clr && wr_hit && wr_addr == addr) begin
                data = wr_data;
            end
            if (addr == '0 && ((ZERO_MODE == 1 && ba) || ZERO_MODE == 2)) begin
                data = '0;
            end
        end
    end

    assign rd_data_a = g_port[0].data;
    assign rd_busy_a = g_port[0].busy;
    assign rd_data_b = g_port[1].data;
    assign rd_busy_b = g_port[1].busy;

endmodule
